// File: rtl/pcm_stream_encoder.sv
// Two-stage pipelined 13-bit PCM segment encoder with TDM channel tagging and valid/ready flow control.
// Optional build macro PCM_ALAW_INVERT_EN applies G.711 even-bit inversion to out_code.
module pcm_stream_encoder #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned TWOS_COMP = 0,
    parameter int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [12:0]     in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            frame_clr,
    output logic [7:0]      out_code,
    output logic [CH_W-1:0] out_chan,
    output logic            out_sof,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     sat_count
);

    localparam int unsigned MAG_W  = 12;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned SAT_W  = 16;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
`ifdef PCM_ALAW_INVERT_EN
    localparam logic [CODE_W-1:0] CODE_MASK = 8'h55;
`else
    localparam logic [CODE_W-1:0] CODE_MASK = 8'h00;
`endif

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_sat;
    logic [MAG_W-1:0] s1_mag;
    logic [CH_W-1:0]  s1_chan;
    logic [CH_W-1:0]  ch_cnt;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_xfer;
    logic             sign_c;
    logic             sat_c;
    logic [MAG_W-1:0] mag_c;
    logic [CH_W-1:0]  tag_c;
    logic [CH_W-1:0]  cnt_next_c;
    logic [2:0]       seg_c;
    logic [3:0]       quant_c;
    logic             unused_mag_lsb;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && s1_adv;

    // The magnitude LSB is below the finest quantiser step
    assign unused_mag_lsb = s1_mag[0];

    // Input format conversion; -4096 has no 12-bit magnitude and saturates
    always_comb begin
        sign_c = in_data[12];
        mag_c  = in_data[11:0];
        sat_c  = 1'b0;
        if (TWOS_COMP != 0 && in_data[12]) begin
            mag_c = MAG_W'(~in_data[11:0]) + MAG_W'(1);
            if (in_data[11:0] == '0) begin
                mag_c = '1;
                sat_c = 1'b1;
            end
        end
    end

    // Channel tag for the accepted sample and next counter value
    always_comb begin
        tag_c      = frame_clr ? '0 : ch_cnt;
        cnt_next_c = frame_clr ? '0 : ch_cnt;
        if (in_xfer) begin
            cnt_next_c = (tag_c == LAST_CH) ? '0 : tag_c + CH_W'(1);
        end
    end

    // Leading-one segment search
    always_comb begin
        seg_c   = 3'd0;
        quant_c = s1_mag[4:1];
        if (s1_mag[11]) begin
            seg_c   = 3'd7;
            quant_c = s1_mag[10:7];
        end else if (s1_mag[10]) begin
            seg_c   = 3'd6;
            quant_c = s1_mag[9:6];
        end else if (s1_mag[9]) begin
            seg_c   = 3'd5;
            quant_c = s1_mag[8:5];
        end else if (s1_mag[8]) begin
            seg_c   = 3'd4;
            quant_c = s1_mag[7:4];
        end else if (s1_mag[7]) begin
            seg_c   = 3'd3;
            quant_c = s1_mag[6:3];
        end else if (s1_mag[6]) begin
            seg_c   = 3'd2;
            quant_c = s1_mag[5:2];
        end else if (s1_mag[5]) begin
            seg_c   = 3'd1;
            quant_c = s1_mag[4:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt <= '0;
        end else begin
            ch_cnt <= cnt_next_c;
        end
    end

    // Stage 1: sign, magnitude, tag and saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sat   <= 1'b0;
            s1_mag   <= '0;
            s1_chan  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_c;
                s1_sat  <= sat_c;
                s1_mag  <= mag_c;
                s1_chan <= tag_c;
            end
        end
    end

    // Stage 2: code register, which is also the output interface
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_chan  <= '0;
            out_sof   <= 1'b0;
            sat_count <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_code <= {s1_sign, seg_c, quant_c} ^ CODE_MASK;
                out_chan <= s1_chan;
                out_sof  <= (s1_chan == '0);
                if (s1_sat && sat_count != '1) begin
                    sat_count <= sat_count + SAT_W'(1);
                end
            end
        end
    end

endmodule
